// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: scancodes are queued in a small FIFO and
// shifted out as 11-bit frames (start, d0..d7, odd parity, stop) with a generated clock.
module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 800,
  parameter int GAP         = 1600,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] din,
  input  logic       din_wr,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TMAX  = (GAP > HALF_PERIOD) ? GAP : HALF_PERIOD;
  localparam int CW    = $clog2(TMAX + 1);
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [10:0]        shift_q, shift_d;
  logic               ps2_clk_q, ps2_clk_d;
  logic               ps2_data_q, ps2_data_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push, pop;
  logic [7:0]         head;

  assign full     = (count_q == (FIFO_AW+1)'(DEPTH));
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) || (count_q != '0);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign head     = mem_q[rd_ptr_q];
  assign push     = din_wr & ~full;

  // Frame sequencer: each bit is one HIGH phase followed by one LOW phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        cnt_d      = '0;
        if (ce && count_q != '0) begin
          pop        = 1'b1;
          shift_d    = {1'b1, ~^head, head, 1'b0};
          idx_d      = 4'd0;
          ps2_data_d = 1'b0;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (ce) begin
          if (cnt_q == HP_LAST) begin
            cnt_d     = '0;
            ps2_clk_d = 1'b0;
            state_d   = ST_LOW;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LOW: begin
        if (ce) begin
          if (cnt_q == HP_LAST) begin
            cnt_d     = '0;
            ps2_clk_d = 1'b1;
            // Next bit is presented on the same edge the clock rises.
            if (idx_q < 4'd10) begin
              idx_d      = idx_q + 4'd1;
              shift_d    = {1'b1, shift_q[10:1]};
              ps2_data_d = shift_q[1];
              state_d    = ST_HIGH;
            end else begin
              ps2_data_d = 1'b1;
              state_d    = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_GAP: begin
        if (ce) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (din_wr & full);
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

endmodule
